// File: rtl/lamp_alternator_ctrl.sv
// Two-lamp alternator: synchronizes i/s, debounces s, and sequences l1/l2 through
// lamp test, blank and an alternating run pattern with a programmable dwell.
module lamp_alternator_ctrl #(
    parameter int DWELL = 8,
    parameter int DEB   = 4,
    parameter int CNT_W = 8
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic i,
    input  logic s,
    output logic l1,
    output logic l2,
    output logic phase,
    output logic swap
);

    typedef enum logic [1:0] {
        BLANK,
        LAMP_TEST,
        RUN_A,
        RUN_B
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB - 1);

    logic             iS1_q, iS2_q;
    logic             sS1_q, sS2_q;
    logic             sDeb_q, sDeb_d;
    logic [CNT_W-1:0] debCnt_q, debCnt_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] dwellCnt_q, dwellCnt_d;
    logic             phase_q, phase_d;
    logic             swap_q, swap_d;
    logic             l1_q, l1_d;
    logic             l2_q, l2_d;
    logic             runNow;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            iS1_q      <= 1'b0;
            iS2_q      <= 1'b0;
            sS1_q      <= 1'b0;
            sS2_q      <= 1'b0;
            sDeb_q     <= 1'b0;
            debCnt_q   <= '0;
            state_q    <= BLANK;
            dwellCnt_q <= '0;
            phase_q    <= 1'b0;
            swap_q     <= 1'b0;
            l1_q       <= 1'b0;
            l2_q       <= 1'b0;
        end else begin
            iS1_q      <= i;
            iS2_q      <= iS1_q;
            sS1_q      <= s;
            sS2_q      <= sS1_q;
            sDeb_q     <= sDeb_d;
            debCnt_q   <= debCnt_d;
            state_q    <= state_d;
            dwellCnt_q <= dwellCnt_d;
            phase_q    <= phase_d;
            swap_q     <= swap_d;
            l1_q       <= l1_d;
            l2_q       <= l2_d;
        end
    end

    // The accepting edge is the one on which the counter would reach DEB.
    always_comb begin
        sDeb_d   = sDeb_q;
        debCnt_d = '0;
        if (sS2_q != sDeb_q) begin
            if (debCnt_q == DEB_LAST) begin
                sDeb_d = sS2_q;
            end else begin
                debCnt_d = debCnt_q + CNT_W'(1);
            end
        end
    end

    assign runNow = (state_q == RUN_A) || (state_q == RUN_B);

    // Dwell advances for every cycle spent lit in a run state; BLANK just holds it.
    always_comb begin
        state_d    = state_q;
        dwellCnt_d = dwellCnt_q;
        phase_d    = phase_q;
        swap_d     = 1'b0;
        if (!iS2_q) begin
            state_d    = LAMP_TEST;
            phase_d    = 1'b0;
            dwellCnt_d = '0;
        end else begin
            if (runNow) begin
                if (dwellCnt_q == DWELL_LAST) begin
                    phase_d    = ~phase_q;
                    dwellCnt_d = '0;
                    swap_d     = 1'b1;
                end else begin
                    dwellCnt_d = dwellCnt_q + CNT_W'(1);
                end
            end
            if (sDeb_q) begin
                state_d = BLANK;
            end else if (state_q == LAMP_TEST) begin
                state_d = RUN_A;
            end else begin
                state_d = phase_d ? RUN_B : RUN_A;
            end
        end
    end

    always_comb begin
        l1_d = 1'b0;
        l2_d = 1'b0;
        case (state_d)
            LAMP_TEST: begin
                l1_d = 1'b1;
                l2_d = 1'b1;
            end
            RUN_A:   l1_d = 1'b1;
            RUN_B:   l2_d = 1'b1;
            default: ;
        endcase
    end

    assign l1    = l1_q;
    assign l2    = l2_q;
    assign phase = phase_q;
    assign swap  = swap_q;

endmodule

// File: tb/tb_lamp_alternator_ctrl.sv
// Directed bench for lamp_alternator_ctrl: a DWELL=3/DEB=4 unit walked through a
// hand-computed edge table, plus a DWELL=1 unit running freely alongside.
module tb_lamp_alternator_ctrl;

    logic Clock = 1'b0;
    logic Resetn;
    logic i, s;
    logic i2, s2;
    logic l1, l2, phase, swap;
    logic l1b, l2b, phaseB, swapB;

    int checks = 0;
    int errors = 0;

    // Expected {l1,l2,phase,swap} after each edge following reset release.
    logic [3:0] expRun [1:57];

    always #5 Clock = ~Clock;

    lamp_alternator_ctrl #(.DWELL(3), .DEB(4), .CNT_W(8)) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .i     (i),
        .s     (s),
        .l1    (l1),
        .l2    (l2),
        .phase (phase),
        .swap  (swap)
    );

    lamp_alternator_ctrl #(.DWELL(1), .DEB(4), .CNT_W(8)) dutFast (
        .Clock (Clock),
        .Resetn(Resetn),
        .i     (i2),
        .s     (s2),
        .l1    (l1b),
        .l2    (l2b),
        .phase (phaseB),
        .swap  (swapB)
    );

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b (l1,l2,phase,swap)", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic iVal, input logic sVal);
        i = iVal;
        s = sVal;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        expRun = '{
            4'b1100, 4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b0111, 4'b0110, 4'b0110, 4'b1001,
            4'b1000, 4'b1000, 4'b0111, 4'b0110, 4'b0110, 4'b1001, 4'b1000, 4'b1000, 4'b0111, 4'b0110,
            4'b0110, 4'b1001, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
            4'b0000, 4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0110, 4'b1001, 4'b1000, 4'b1000, 4'b0111,
            4'b0110, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1100, 4'b1100, 4'b1100, 4'b0000, 4'b0000,
            4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0111, 4'b0110
        };

        Resetn = 1'b0;
        i      = 1'b0;
        s      = 1'b0;
        i2     = 1'b1;
        s2     = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        checkOutput("reset dwell3", {l1, l2, phase, swap}, 4'b0000);
        checkOutput("reset dwell1", {l1b, l2b, phaseB, swapB}, 4'b0000);

        @(negedge Clock);
        Resetn = 1'b1;

        // Lamp test, run, glitch, blank/resume, priority and restart in one pass.
        for (int e = 1; e <= 57; e++) begin
            applyStimulus((e >= 2) && !(e >= 44 && e <= 46),
                          (e >= 12 && e <= 14) || (e >= 18 && e <= 26) || (e >= 36 && e <= 46));
            checkOutput($sformatf("edge%0d dwell3", e), {l1, l2, phase, swap}, expRun[e]);
            if (e <= 10) begin
                if (e <= 2)
                    checkOutput($sformatf("edge%0d dwell1", e), {l1b, l2b, phaseB, swapB}, 4'b1100);
                else if (e == 3)
                    checkOutput("edge3 dwell1", {l1b, l2b, phaseB, swapB}, 4'b1000);
                else
                    checkOutput($sformatf("edge%0d dwell1", e), {l1b, l2b, phaseB, swapB},
                                (e % 2 == 0) ? 4'b0111 : 4'b1001);
            end
        end

        #2;
        Resetn = 1'b0;
        #1;
        checkOutput("async reset dwell3", {l1, l2, phase, swap}, 4'b0000);
        checkOutput("async reset dwell1", {l1b, l2b, phaseB, swapB}, 4'b0000);
        @(posedge Clock);
        #1;
        checkOutput("reset held", {l1, l2, phase, swap}, 4'b0000);

        @(negedge Clock);
        Resetn = 1'b1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("post reset edge1", {l1, l2, phase, swap}, 4'b1100);
        applyStimulus(1'b1, 1'b0);
        checkOutput("post reset edge2", {l1, l2, phase, swap}, 4'b1100);
        applyStimulus(1'b1, 1'b0);
        checkOutput("post reset edge3", {l1, l2, phase, swap}, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
